// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, default width and buffer occupancy states.
package alu_pkg;

  localparam int unsigned AluWidth = 32;
  localparam int unsigned AluOpW   = 3;

  // Op tag encodings shared with the ALU opcode decoder.
  localparam logic [AluOpW-1:0] AluOpAdd  = 3'd0;
  localparam logic [AluOpW-1:0] AluOpSub  = 3'd1;
  localparam logic [AluOpW-1:0] AluOpXor  = 3'd2;
  localparam logic [AluOpW-1:0] AluOpSlt  = 3'd3;
  localparam logic [AluOpW-1:0] AluOpAnd  = 3'd4;
  localparam logic [AluOpW-1:0] AluOpNand = 3'd5;
  localparam logic [AluOpW-1:0] AluOpNor  = 3'd6;
  localparam logic [AluOpW-1:0] AluOpOr   = 3'd7;

  // Occupancy state doubles as the visible count.
  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag derivation for one result word.
module alu_flag_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  output logic             o_zero,
  output logic             o_negative
);

  // Flags are a pure function of the word.
  always_comb begin
    o_zero     = (i_word == '0);
    o_negative = i_word[WIDTH-1];
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry FIFO holding ALU results and flags between the ALU and writeback.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth,
  parameter int unsigned OPW   = AluOpW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [OPW-1:0]   out_op,
  output logic [1:0]       count
);

  occ_e             r_occ, w_occ_next;
  logic             w_push, w_pop;
  logic             w_wr_head, w_wr_tail, w_mv_tail;
  logic             w_in_zero, w_in_negative;

  logic [WIDTH-1:0] r_head_result, r_tail_result;
  logic             r_head_zero, r_tail_zero;
  logic             r_head_neg, r_tail_neg;
  logic             r_head_carry, r_tail_carry;
  logic             r_head_ovf, r_tail_ovf;
  logic [OPW-1:0]   r_head_op, r_tail_op;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .i_word     (in_result),
    .o_zero     (w_in_zero),
    .o_negative (w_in_negative)
  );

  // Handshake status comes only from registered occupancy.
  always_comb begin
    in_ready  = (r_occ != OccFull);
    out_valid = (r_occ != OccEmpty);
    count     = r_occ;
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
  end

  // Next occupancy and slot write strobes; flush overrides everything.
  always_comb begin
    w_occ_next = r_occ;
    w_wr_head  = 1'b0;
    w_wr_tail  = 1'b0;
    w_mv_tail  = 1'b0;
    if (flush) begin
      w_occ_next = OccEmpty;
    end else begin
      unique case (r_occ)
        OccEmpty: begin
          if (w_push) begin
            w_occ_next = OccOne;
            w_wr_head  = 1'b1;
          end
        end
        OccOne: begin
          if (w_push && w_pop) begin
            w_wr_head = 1'b1;
          end else if (w_push) begin
            w_occ_next = OccFull;
            w_wr_tail  = 1'b1;
          end else if (w_pop) begin
            w_occ_next = OccEmpty;
          end
        end
        OccFull: begin
          if (w_pop) begin
            w_occ_next = OccOne;
            w_mv_tail  = 1'b1;
          end
        end
        default: w_occ_next = OccEmpty;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= OccEmpty;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  // Head slot: loaded from the input or from the tail when the head drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_result <= '0;
      r_head_zero   <= 1'b0;
      r_head_neg    <= 1'b0;
      r_head_carry  <= 1'b0;
      r_head_ovf    <= 1'b0;
      r_head_op     <= '0;
    end else if (w_wr_head) begin
      r_head_result <= in_result;
      r_head_zero   <= w_in_zero;
      r_head_neg    <= w_in_negative;
      r_head_carry  <= in_carry;
      r_head_ovf    <= in_overflow;
      r_head_op     <= in_op;
    end else if (w_mv_tail) begin
      r_head_result <= r_tail_result;
      r_head_zero   <= r_tail_zero;
      r_head_neg    <= r_tail_neg;
      r_head_carry  <= r_tail_carry;
      r_head_ovf    <= r_tail_ovf;
      r_head_op     <= r_tail_op;
    end
  end

  // Tail slot: only written when pushing behind an occupied head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail_result <= '0;
      r_tail_zero   <= 1'b0;
      r_tail_neg    <= 1'b0;
      r_tail_carry  <= 1'b0;
      r_tail_ovf    <= 1'b0;
      r_tail_op     <= '0;
    end else if (w_wr_tail) begin
      r_tail_result <= in_result;
      r_tail_zero   <= w_in_zero;
      r_tail_neg    <= w_in_negative;
      r_tail_carry  <= in_carry;
      r_tail_ovf    <= in_overflow;
      r_tail_op     <= in_op;
    end
  end

  // Outputs always present the head slot.
  always_comb begin
    out_result   = r_head_result;
    out_zero     = r_head_zero;
    out_negative = r_head_neg;
    out_carry    = r_head_carry;
    out_overflow = r_head_ovf;
    out_op       = r_head_op;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Two-entry registered result buffer directly downstream of the 32-bit ALU (XOR/ADD/SUB/SLT/logic slices) in the multicycle CPU. It captures each ALU result with its carry/overflow outputs and op tag, derives zero/negative flags, and holds them for the writeback/branch-decision logic under a valid/ready handshake. This decouples ALU evaluation from writeback so the control FSM can advance a cycle early without losing a result.

## Interface
Parameters:
- `WIDTH`, 32: data width of ALU result.
- `OPW`, 3: width of ALU op tag (matches shared ALU opcode encoding).

Ports:
- `clk` in 1: the block's single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low; clears all state.
- `flush` in 1: synchronous discard of all buffered entries.
- `in_valid` in 1: ALU result presented this cycle.
- `in_ready` out 1: buffer can accept; equals (count != 2).
- `in_result` in WIDTH: ALU result word.
- `in_carry` in 1: ALU carry-out.
- `in_overflow` in 1: ALU signed overflow.
- `in_op` in OPW: op tag of the operation that produced the result.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes head this cycle.
- `out_result` out WIDTH: head result.
- `out_zero` out 1: head result == 0.
- `out_negative` out 1: head result[WIDTH-1].
- `out_carry`, `out_overflow` out 1 each: stored ALU flags of head.
- `out_op` out OPW: head op tag.
- `count` out 2: occupancy 0..2.

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- Entry storage: two slots (head, tail), each {result, zero, negative, carry, overflow, op}. Zero/negative computed from `in_result` at push time and stored, not recomputed at output.
- Occupancy states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push -> ONE, entry written to head. pop impossible (out_valid=0).
  - ONE: push only -> FULL, entry to tail. pop only -> EMPTY. push+pop -> ONE, new entry written to head.
  - FULL: in_ready=0, no push. pop -> ONE, tail moves to head.
- Order strictly FIFO; no entry reordered, duplicated or dropped except by flush/reset.
- `flush`: next state EMPTY, overrides push and pop in the same cycle; the entry offered that cycle is discarded.
- Out_* fields reflect head slot; when out_valid=0 they are held at last value (don't-care to consumer, but must not be X after reset).
- in_valid while in_ready=0: ignored; upstream holds data (standard valid/ready, no combinational path from in_valid to in_ready).
- No path from out_ready to in_ready combinationally beyond count (in_ready depends only on registered count).

## Timing
- Reset (rst_n low, asynchronous): count=0, out_valid=0, in_ready=1, all out_* data/flags = 0; takes effect immediately, regardless of clock.
- Reset deasserted mid-transfer: all buffered entries lost; first push after reset starts at EMPTY.
- Latency: push at edge N -> out_valid=1 with that entry after edge N (visible cycle N+1). No combinational bypass input->output.
- Throughput: one push and one pop per cycle sustained when count=1.
- Back-pressure: out_ready low for two pushes -> FULL, in_ready low the following cycle.
- Flush at edge N: count=0 and out_valid=0 from cycle N+1; in_ready=1 in cycle N+1.

## Structure
- Shared package `alu_pkg`: ALU op encodings (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR) as OPW-bit constants, WIDTH default, occupancy constants EMPTY/ONE/FULL.
- One sub-module: `alu_flag_gen` (combinational zero and negative from a WIDTH-bit word), instantiated once on the input side.
- Everything else (slots, count, muxing) in the top module.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle -> count=0, out_valid=0, in_ready=1, out_result=0 immediately.
- Single push: in_result=32'h0000_0000, op=XOR -> next cycle out_valid=1, out_zero=1, out_negative=0, out_op=XOR; pop -> count=0.
- Fill and drain: out_ready=0, push 32'h8000_0001 then 32'h0000_0005 -> count=2, in_ready=0, third push ignored; then out_ready=1 -> outputs 32'h8000_0001 (negative=1) then 32'h0000_0005, in order.
- Simultaneous push/pop at count=1: stream 100 results back-to-back with out_ready=1 -> count stays 1, every result appears exactly once, one-cycle latency.
- Flush priority: count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, offered entry not later seen.
- Flag pass-through: push in_carry=1, in_overflow=1, in_result=32'h7FFF_FFFF -> out_carry=1, out_overflow=1, out_zero=0, out_negative=0.
